mac_ctrl: RTL and testbench
===========================

MAC_CTRL -- requirements
Module: mac_ctrl

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high. Ports are listed below as name, direction, width, meaning.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  request to process one input matrix; sampled only in IDLE.
REQ-005 busy  out  1  high in every state except IDLE.
REQ-006 done  out  1  single-cycle pulse when the matrix is fully processed.
REQ-007 load_req  out  1  asks the input buffer to load the X rows.
REQ-008 load_ack  in  1  input buffer ready; sampled only in LOAD.
REQ-009 ALU_en  out  1  MAC datapath enable.
REQ-010 four_results_ready, all_results_ready  in  1 each  datapath group-end and matrix-end flags.
REQ-011 MU1..MU4  in  18 each  datapath accumulators.
REQ-012 res_we  out  1  result-memory write strobe.
REQ-013 res_addr  out  4  result word address, 0..15.
REQ-014 res_wdata  out  18  result word.
REQ-015 seq_err  out  1  sticky datapath-sequence error flag.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, COMPUTE, FLUSH, DONE.
REQ-017 IDLE->LOAD on start=1; LOAD holds load_req=1 until load_ack=1, then goes to COMPUTE.
REQ-018 COMPUTE SHALL assert ALU_en for exactly 32 consecutive cycles, counted k=0..31 by a 5-bit counter, then go to FLUSH.
REQ-019 four_results_ready is expected at k=7,15,23,31; all_results_ready is expected only at k=31. A flag at any other k, or a missing flag, SHALL set seq_err, which stays set until reset. Sequencing SHALL NOT change on error.
REQ-020 The cycle after four_results_ready=1, MU1..MU4 SHALL be captured into four holding registers; group index g (0..3) increments per capture.
REQ-021 A capture SHALL drain over the next 4 cycles as res_we=1 writes, in order MU1,MU2,MU3,MU4, at res_addr = 4*g + row (row 0..3). Drain overlaps compute.
REQ-022 FLUSH SHALL wait until the final capture and its 4 writes complete, then go to DONE.
REQ-023 DONE SHALL pulse done=1 for one cycle and return to IDLE; 16 writes per matrix total.
REQ-024 start while busy SHALL be ignored; start held high in DONE SHALL not be seen until IDLE.
REQ-025 Latency from load_ack to done SHALL be 32 (compute) + 1 (capture) + 4 (drain) + 1 (DONE) = 38 cycles.
REQ-026 res_addr and res_wdata SHALL be 0 whenever res_we=0.

Reset
REQ-027 On rst=1 at any time, including mid-COMPUTE or mid-drain: state=IDLE, counters=0, holding registers=0, all outputs 0 (seq_err cleared); no write in progress completes.

Configuration
REQ-028 Macro MAC_CTRL_CLIP_EN: when defined, res_wdata = min(MU, 65535), so bits 17:16 are always 0. When undefined, res_wdata passes the full 18-bit MU value unmodified.

Verification
REQ-029 Nominal: start, load_ack after 3 cycles, model flags at k=7/15/23/31 with MU=row*100+g -> 16 writes, addr 0..15, data matching, done 38 cycles after load_ack, seq_err=0.
REQ-030 Early flag: four_results_ready at k=6 -> seq_err=1 stays high; still 16 writes and done.
REQ-031 Reset at k=12 -> next cycle all outputs 0, IDLE; a fresh start then completes normally.
REQ-032 start pulsed during COMPUTE and held high through DONE -> exactly one extra run, beginning after IDLE.
REQ-033 MU1=18'h3FFFF at group 0: with MAC_CTRL_CLIP_EN, address 0 gets 65535; without it, address 0 gets 262143.
REQ-034 load_ack withheld 20 cycles -> load_req stays high, ALU_en stays 0 until the ack.

Source files
------------

// File: rtl/mac_ctrl.sv
// mac_ctrl: sequencer for one matrix pass through the MAC datapath.
//
// A start request loads the X rows (load_req/load_ack handshake). The
// datapath then runs for exactly 32 enabled cycles. It is split into four
// groups of 8 cycles. After each group the four accumulators MU1..MU4 are
// captured and drained into result memory as four consecutive writes.
// Once the last group has drained, done pulses and the block returns to idle.
//
// Ports
//   clk                 in   1   sole clock, rising edge
//   rst                 in   1   synchronous active-high reset
//   start               in   1   process one matrix (seen only in IDLE)
//   busy                out  1   high in every state except IDLE
//   done                out  1   one-cycle pulse at end of matrix
//   load_req            out  1   request input buffer load
//   load_ack            in   1   input buffer ready (seen only in LOAD)
//   ALU_en              out  1   MAC datapath enable
//   four_results_ready  in   1   datapath group-end flag
//   all_results_ready   in   1   datapath matrix-end flag
//   MU1..MU4            in   18  datapath accumulators
//   res_we              out  1   result-memory write strobe
//   res_addr            out  4   result word address (0 when idle)
//   res_wdata           out  18  result word (0 when idle)
//   seq_err             out  1   sticky datapath-sequence error
//
// Configuration macro: MAC_CTRL_CLIP_EN
//   When defined, each result word is saturated to 65535.
//   When undefined, the full 18-bit accumulator value is written.

module mac_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        load_req,
    input  logic        load_ack,
    output logic        ALU_en,
    input  logic        four_results_ready,
    input  logic        all_results_ready,
    input  logic [17:0] MU1,
    input  logic [17:0] MU2,
    input  logic [17:0] MU3,
    input  logic [17:0] MU4,
    output logic        res_we,
    output logic [3:0]  res_addr,
    output logic [17:0] res_wdata,
    output logic        seq_err
);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, FLUSH, DONE} state_t;

    state_t           state_q, state_d;
    logic [4:0]       k_q, k_d;
    logic             capPend_q, capPend_d;
    logic [3:0][17:0] hold_q, hold_d;
    logic [1:0]       g_q, g_d;
    logic [1:0]       grpNext_q, grpNext_d;
    logic             draining_q, draining_d;
    logic [1:0]       row_q, row_d;
    logic             seqErr_q, seqErr_d;
    logic [17:0]      rowWord;
    logic [17:0]      outWord;

    // State register and all datapath-control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            capPend_q  <= 1'b0;
            hold_q     <= '0;
            g_q        <= '0;
            grpNext_q  <= '0;
            draining_q <= 1'b0;
            row_q      <= '0;
            seqErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            capPend_q  <= capPend_d;
            hold_q     <= hold_d;
            g_q        <= g_d;
            grpNext_q  <= grpNext_d;
            draining_q <= draining_d;
            row_q      <= row_d;
            seqErr_q   <= seqErr_d;
        end
    end

    // Next-state logic.
    // Capture and drain timing follows the fixed k schedule, not the
    // incoming flags. A misbehaving datapath can therefore only raise
    // seq_err. It never changes the number of writes or the latency.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        capPend_d  = 1'b0;
        hold_d     = hold_q;
        g_d        = g_q;
        grpNext_d  = grpNext_q;
        draining_d = draining_q;
        row_d      = row_q;
        seqErr_d   = seqErr_q;

        // A drain writes rows 0..3 on four consecutive cycles.
        if (draining_q) begin
            row_d = row_q + 2'd1;
            if (row_q == 2'd3) begin
                draining_d = 1'b0;
            end
        end

        // The cycle after a group end, latch the accumulators.
        // Start draining that group on the following cycle.
        if (capPend_q) begin
            hold_d     = {MU4, MU3, MU2, MU1};
            g_d        = grpNext_q;
            grpNext_d  = grpNext_q + 2'd1;
            draining_d = 1'b1;
            row_d      = 2'd0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD;
                    grpNext_d = 2'd0;
                end
            end
            LOAD: begin
                if (load_ack) begin
                    state_d = COMPUTE;
                    k_d     = 5'd0;
                end
            end
            COMPUTE: begin
                // Flag the datapath if its group-end or matrix-end signal
                // arrives on the wrong cycle or does not arrive at all.
                if ((four_results_ready != (k_q[2:0] == 3'd7)) ||
                    (all_results_ready  != (k_q == 5'd31))) begin
                    seqErr_d = 1'b1;
                end
                capPend_d = (k_q[2:0] == 3'd7);
                k_d       = k_q + 5'd1;
                if (k_q == 5'd31) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (draining_q && (row_q == 2'd3) && !capPend_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. The result bus is forced to zero whenever no write
    // is in progress.
    always_comb begin
        rowWord = hold_q[row_q];
`ifdef MAC_CTRL_CLIP_EN
        outWord = (rowWord > 18'd65535) ? 18'd65535 : rowWord;
`else
        outWord = rowWord;
`endif
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        load_req  = (state_q == LOAD);
        ALU_en    = (state_q == COMPUTE);
        seq_err   = seqErr_q;
        res_we    = draining_q;
        res_addr  = draining_q ? {g_q, row_q} : 4'd0;
        res_wdata = draining_q ? outWord : 18'd0;
    end

endmodule

// File: tb/tb_mac_ctrl.sv
// tb_mac_ctrl: directed scoreboard bench for mac_ctrl.
// The bench pushes the expected result writes when it drives a group's
// accumulator values. A negedge monitor pops and checks each write.

module tb_mac_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        load_ack = 1'b0;
    logic        four_results_ready = 1'b0;
    logic        all_results_ready = 1'b0;
    logic [17:0] MU1 = '0;
    logic [17:0] MU2 = '0;
    logic [17:0] MU3 = '0;
    logic [17:0] MU4 = '0;
    logic        busy;
    logic        done;
    logic        load_req;
    logic        ALU_en;
    logic        res_we;
    logic [3:0]  res_addr;
    logic [17:0] res_wdata;
    logic        seq_err;

    int          total = 0;
    int          bad = 0;
    int          writes = 0;
    bit          monOn = 1'b0;
    logic [21:0] expQ[$];
    logic [21:0] expEntry;

    always #5 clk = ~clk;

    mac_ctrl dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .load_req(load_req),
        .load_ack(load_ack),
        .ALU_en(ALU_en),
        .four_results_ready(four_results_ready),
        .all_results_ready(all_results_ready),
        .MU1(MU1),
        .MU2(MU2),
        .MU3(MU3),
        .MU4(MU4),
        .res_we(res_we),
        .res_addr(res_addr),
        .res_wdata(res_wdata),
        .seq_err(seq_err)
    );

    // Expected value of a result word after optional saturation.
    function automatic logic [17:0] clipModel(input logic [17:0] v);
`ifdef MAC_CTRL_CLIP_EN
        return (v > 18'd65535) ? 18'd65535 : v;
`else
        return v;
`endif
    endfunction

    // Accumulator value the bench drives for a given row and group.
    function automatic logic [17:0] muVal(input int row, input int g, input bit bigMu);
        if (bigMu && row == 0 && g == 0) begin
            return 18'h3FFFF;
        end
        return 18'(row * 100 + g);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every write must match the queue head. The bus
    // must read zero whenever no write is in progress.
    always @(negedge clk) begin
        if (monOn) begin
            if (res_we === 1'b1) begin
                writes++;
                if (expQ.size() == 0) begin
                    checkOutput("writeExpected", 32'(expQ.size()), 32'd1);
                end else begin
                    expEntry = expQ.pop_front();
                    checkOutput("writeAddr", 32'(res_addr), 32'(expEntry[21:18]));
                    checkOutput("writeData", 32'(res_wdata), 32'(expEntry[17:0]));
                end
            end else begin
                checkOutput("idleBus", 32'({res_we, res_addr, res_wdata}), 32'd0);
            end
        end
    end

    task automatic doReset(input string tag);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput(tag, 32'({busy, done, load_req, ALU_en, res_we, seq_err, res_addr, res_wdata}), 32'd0);
        stepCycle();
    endtask

    // One matrix pass.
    // ackDelay: cycles load_ack is withheld.
    // badK: k for an early group flag (-1 = none).
    // resetK: k for a mid-run reset (-1 = none).
    // bigMu: drive the oversized MU1 value in group 0.
    // pulseStart: pulse start during compute.
    // holdStartEnd: hold start high from flush through the next start.
    // skipStart: the run is already in LOAD when the task is called.
    // expErr: expected final value of seq_err.
    task automatic applyStimulus(input int ackDelay, input int badK, input int resetK,
                                 input bit bigMu, input bit pulseStart, input bit holdStartEnd,
                                 input bit skipStart, input bit expErr);
        int cyc;
        int doneAt;
        int g;
        writes = 0;
        if (!skipStart) begin
            start = 1'b1;
            stepCycle();
            start = 1'b0;
        end
        for (int i = 0; i < ackDelay; i++) begin
            @(negedge clk);
            checkOutput("loadWait", 32'({load_req, ALU_en}), 32'b10);
            stepCycle();
        end
        load_ack = 1'b1;
        @(negedge clk);
        checkOutput("loadReq", 32'({load_req, ALU_en}), 32'b10);
        stepCycle();
        load_ack = 1'b0;
        cyc = 1;
        for (int k = 0; k < 32; k++) begin
            g = (k == 0) ? 0 : (k - 1) / 8;
            MU1 = muVal(0, g, bigMu);
            MU2 = muVal(1, g, bigMu);
            MU3 = muVal(2, g, bigMu);
            MU4 = muVal(3, g, bigMu);
            if (k % 8 == 1) begin
                for (int r = 0; r < 4; r++) begin
                    expQ.push_back({4'(4 * g + r), clipModel(muVal(r, g, bigMu))});
                end
            end
            if (badK >= 0 && k / 8 == badK / 8) begin
                four_results_ready = (k == badK);
            end else begin
                four_results_ready = (k % 8 == 7);
            end
            all_results_ready = (k == 31);
            start = pulseStart && (k == 5);
            if (k == resetK) begin
                four_results_ready = 1'b0;
                all_results_ready = 1'b0;
                rst = 1'b1;
                stepCycle();
                rst = 1'b0;
                expQ.delete();
                @(negedge clk);
                checkOutput("afterReset",
                    32'({busy, done, load_req, ALU_en, res_we, seq_err, res_addr, res_wdata}), 32'd0);
                stepCycle();
                return;
            end
            @(negedge clk);
            checkOutput("computeEn", 32'({ALU_en, busy, load_req}), 32'b110);
            if (badK >= 0 && k == badK + 1) begin
                checkOutput("seqErrSet", 32'(seq_err), 32'd1);
            end
            stepCycle();
            cyc++;
        end
        four_results_ready = 1'b0;
        all_results_ready = 1'b0;
        start = 1'b0;
        if (holdStartEnd) begin
            start = 1'b1;
        end
        doneAt = -1;
        for (int i = 0; i < 12 && doneAt < 0; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                doneAt = cyc;
            end
            stepCycle();
            cyc++;
            if (cyc == 34) begin
                MU1 = '0;
                MU2 = '0;
                MU3 = '0;
                MU4 = '0;
            end
        end
        checkOutput("doneLatency", 32'(doneAt), 32'd38);
        @(negedge clk);
        checkOutput("doneOnce", 32'({done, busy}), 32'b00);
        checkOutput("writeCount", 32'(writes), 32'd16);
        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("seqErr", 32'(seq_err), 32'(expErr));
        if (holdStartEnd) begin
            stepCycle();
            checkOutput("restartLoad", 32'({busy, load_req}), 32'b11);
            start = 1'b0;
        end else begin
            stepCycle();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] mac_ctrl bench start");
        rst = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;
        monOn = 1'b1;
        @(negedge clk);
        checkOutput("resetState",
            32'({busy, done, load_req, ALU_en, res_we, seq_err, res_addr, res_wdata}), 32'd0);
        stepCycle();

        $display("[TB] nominal run");
        applyStimulus(3, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] early group flag");
        applyStimulus(0, 6, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        @(negedge clk);
        checkOutput("seqErrSticky", 32'(seq_err), 32'd1);
        stepCycle();
        doReset("resetClear");

        $display("[TB] reset mid compute");
        applyStimulus(0, 6, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] start while busy");
        applyStimulus(1, -1, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, -1, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("noThirdRun", 32'(busy), 32'd0);
            stepCycle();
        end

        $display("[TB] oversized accumulator");
        applyStimulus(2, -1, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] delayed load ack");
        applyStimulus(20, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        stepCycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
